// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, frame-locking arbiter sharing one async-FIFO write port among byte producers
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 3,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
    input  logic                          full,
    output logic                          w_inc,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          busy,
    output logic [1:0]                    owner
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t                fsm_q;
    logic [1:0]            owner_q;
    logic [1:0]            last_owner_q;
    logic [3:0]            beat_q;
    logic [3:0]            req_p;
    logic [3:0]            last_p;
    logic [DATA_WIDTH-1:0] slot [4];
    logic [1:0]            winner_d;
    logic [2:0]            s;
    logic                  found;
    logic                  accept;

    assign req_p  = 4'(req);
    assign last_p = 4'(last);

    for (genvar i = 0; i < 4; i++) begin : g_slot
        if (i < NUM_REQ) begin : g_on
            assign slot[i] = data[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_off
            assign slot[i] = '0;
        end
    end

    assign accept = (fsm_q == LOCK) && req_p[owner_q] && !full;
    assign w_inc  = accept;
    assign ack    = accept ? NUM_REQ'(4'b0001 << owner_q) : '0;
    assign w_data = accept ? slot[owner_q] : '0;
    assign busy   = (fsm_q == LOCK);
    assign owner  = owner_q;

    // Round-robin search starting just after the previous owner
    always_comb begin
        winner_d = last_owner_q;
        found    = 1'b0;
        s        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            s = {1'b0, last_owner_q} + 3'(k);
            s = (s >= 3'(NUM_REQ)) ? s - 3'(NUM_REQ) : s;
            if (!found && req_p[s[1:0]]) begin
                winner_d = s[1:0];
                found    = 1'b1;
            end
        end
    end

    // Grant FSM: one arbitration cycle in IDLE, then hold the lock until frame end, burst limit or abandon
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q        <= IDLE;
            owner_q      <= 2'd0;
            last_owner_q <= 2'(NUM_REQ - 1);
            beat_q       <= 4'd0;
        end else if (fsm_q == IDLE) begin
            if (|req) begin
                owner_q <= winner_d;
                beat_q  <= 4'd0;
                fsm_q   <= LOCK;
            end
        end else if (accept) begin
            if (last_p[owner_q] || beat_q == 4'(MAX_BURST - 1)) begin
                last_owner_q <= owner_q;
                fsm_q        <= IDLE;
            end else begin
                beat_q <= beat_q + 4'd1;
            end
        end else if (!req_p[owner_q]) begin
            last_owner_q <= owner_q;
            fsm_q        <= IDLE;
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the async TX FIFO's write-clock side among NUM_REQ byte producers, e.g. system controller, register-file readback and ALU result.
- Round-robin grant with frame locking, so a multi-byte frame from one producer is never interleaved with another producer's bytes.
- Drives the FIFO's write-increment and write-data inputs and honours its full flag. Sits entirely in the write-clock domain.

Parameters:
- DATA_WIDTH, 8, byte width of each producer's data and of w_data.
- NUM_REQ, 3, number of requesters (2..4); owner encoding is 2 bits.
- MAX_BURST, 4, max bytes accepted per grant before forced release (1..15).

Ports:
- clk  in  1  write-domain clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester "byte valid"; held until acked.
- last  in  NUM_REQ  per-requester "this byte ends the frame"; qualified by req.
- data  in  NUM_REQ*DATA_WIDTH  requester i's byte at [i*DATA_WIDTH +: DATA_WIDTH].
- full  in  1  FIFO full flag (write domain).
- w_inc  out  1  FIFO write increment; one byte written per cycle high.
- w_data  out  DATA_WIDTH  byte to FIFO write port.
- ack  out  NUM_REQ  one-hot: requester's byte taken this cycle.
- busy  out  1  high while a grant is held.
- owner  out  2  index of current or last granted requester.

Behaviour:
- Registered state: fsm {IDLE, LOCK}, owner, last_owner, beat_cnt (4 bits).
- Reset (async, rst=0): fsm=IDLE, owner=0, last_owner=NUM_REQ-1 (requester 0 has first priority), beat_cnt=0. Outputs w_inc=0, ack=0, busy=0, w_data=0.
- w_inc, ack and w_data are combinational from registered state, req and full. This keeps w_inc aligned with the FIFO's same-cycle full check.
- accept = (fsm==LOCK) && req[owner] && !full.
- w_inc = accept; ack = accept ? (1<<owner) : 0; w_data = accept ? data slice[owner] : 0.
- busy = (fsm==LOCK), registered.
- IDLE:
  - No writes.
  - If any req bit is set, grant the first set bit searching last_owner+1, last_owner+2, … modulo NUM_REQ.
  - On grant: owner←winner, beat_cnt←0, fsm←LOCK.
  - Arbitration costs exactly 1 cycle: req rising at edge N gives the earliest w_inc in the cycle after edge N+1.
- LOCK:
  - accept with last[owner]=1 or beat_cnt==MAX_BURST-1: end grant. last_owner←owner, fsm←IDLE.
  - accept otherwise: beat_cnt←beat_cnt+1, stay LOCK.
  - req[owner]=0, no accept: producer abandoned the frame. last_owner←owner, fsm←IDLE.
  - req[owner]=1, full=1: stall. No write, no ack, beat_cnt held, lock held indefinitely. Other requesters are not serviced.
- Requests from non-owners are ignored (no ack) while locked; they remain pending.
- Back-to-back: after release, the next grant occurs on the following IDLE cycle. Worst-case gap between frames is 1 idle cycle.
- MAX_BURST release gives fairness; a frame longer than MAX_BURST resumes only after other pending requesters have had a turn.
- An owner that is the sole requester regains the grant after one IDLE cycle.
- Reset mid-frame: all state cleared immediately. Any partially written frame in the FIFO is the producer's concern.
- Never: w_inc with full=1, more than one ack bit set, or ack without w_inc.

Test Plan:
- Reset, then req=3'b001, data0=0xA5, last0=1, full=0 → one cycle IDLE. Then w_inc=1, w_data=0xA5, ack=001 for one cycle; busy 1 then 0; owner=0.
- req=3'b111, each with last=1, held and re-asserted → grants in order 0,1,2,0. w_data sequence matches the per-requester bytes; exactly one ack bit set per write.
- Requester 1 sends a 3-byte frame (last on byte 3) while req0 and req2 are asserted → three consecutive w_inc with bytes from requester 1 only. Then requester 2 is granted.
- Requester 0 streams 6 bytes with no last, MAX_BURST=4, req2 pending → 4 bytes written, release, requester 2 served. Then requester 0 resumes with byte 5.
- Owner locked, full=1 for 5 cycles mid-frame → w_inc=0 and ack=0 throughout, beat_cnt unchanged. The write resumes in the first cycle full=0 with the same byte.
- rst pulsed low mid-frame → busy, w_inc and ack drop asynchronously. After release, requester 0 has first priority.
